fifo_row_packer: RTL and testbench

//  Drains the byte-wide weight/input FIFO and packs consecutive entries into full

---
 rtl/fifo_row_packer_if.sv | 31 +++
 rtl/fifo_row_packer.sv | 119 +++++++++++
 tb/tb_fifo_row_packer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_row_packer_if.sv
// Bundle of the command, FIFO-drain and row-output signals of fifo_row_packer.
//   command : start, num_rows (to packer); busy, done (from packer)
//   FIFO    : fifo_data, fifo_empty (to packer); fifo_next_en (from packer)
//   row     : row_data, row_valid (from packer); row_ready (to packer)
// master is the packer side, slave is the surrounding environment.
interface fifo_row_packer_if #(
  parameter int unsigned FIFO_WIDTH    = 8,
  parameter int unsigned ROW_LENGTH    = 14,
  parameter int unsigned ROW_CNT_WIDTH = 8
);
  logic                             start;
  logic [ROW_CNT_WIDTH-1:0]         num_rows;
  logic                             busy;
  logic                             done;
  logic [FIFO_WIDTH-1:0]            fifo_data;
  logic                             fifo_empty;
  logic                             fifo_next_en;
  logic [ROW_LENGTH*FIFO_WIDTH-1:0] row_data;
  logic                             row_valid;
  logic                             row_ready;

  modport master (
    input  start, num_rows, fifo_data, fifo_empty, row_ready,
    output busy, done, fifo_next_en, row_data, row_valid
  );

  modport slave (
    output start, num_rows, fifo_data, fifo_empty, row_ready,
    input  busy, done, fifo_next_en, row_data, row_valid
  );
endinterface

// File: rtl/fifo_row_packer.sv
// Drains a show-ahead byte FIFO and packs ROW_LENGTH consecutive entries into
// one systolic-array row, presented over valid/ready. A command (start +
// num_rows) transfers num_rows rows and ends with a one-cycle done pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_row_packer_if.master (command, FIFO drain, row output)
module fifo_row_packer #(
  parameter int unsigned FIFO_WIDTH    = 8,
  parameter int unsigned ROW_LENGTH    = 14,
  parameter int unsigned ROW_CNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  fifo_row_packer_if.master bus
);

  localparam int unsigned LANE_W = $clog2(ROW_LENGTH);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PRESENT
  } state_t;

  state_t                           state_q, state_d;
  logic [LANE_W-1:0]                lane_cnt_q, lane_cnt_d;
  logic [ROW_CNT_WIDTH-1:0]         row_cnt_q, row_cnt_d;
  logic [ROW_CNT_WIDTH-1:0]         rows_tgt_q, rows_tgt_d;
  logic [ROW_LENGTH*FIFO_WIDTH-1:0] row_data_q, row_data_d;
  logic                             done_q, done_d;

  logic                             pop;
  logic                             last_lane;
  // One bit wider so row_cnt+1 never wraps when rows_tgt is all ones.
  logic [ROW_CNT_WIDTH:0]           row_cnt_inc;

  assign pop         = (state_q == FILL) && !bus.fifo_empty;
  assign last_lane   = (lane_cnt_q == LANE_W'(ROW_LENGTH - 1));
  assign row_cnt_inc = {1'b0, row_cnt_q} + (ROW_CNT_WIDTH + 1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      row_cnt_q  <= '0;
      rows_tgt_q <= '0;
      row_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      row_cnt_q  <= row_cnt_d;
      rows_tgt_q <= rows_tgt_d;
      row_data_q <= row_data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    row_cnt_d  = row_cnt_q;
    rows_tgt_d = rows_tgt_q;
    row_data_d = row_data_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_rows != '0) begin
            rows_tgt_d = bus.num_rows;
            row_cnt_d  = '0;
            lane_cnt_d = '0;
            state_d    = FILL;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      FILL: begin
        if (pop) begin
          // Lanes are overwritten in place; stale lanes are never cleared.
          for (int unsigned k = 0; k < ROW_LENGTH; k++) begin
            if (lane_cnt_q == LANE_W'(k)) begin
              row_data_d[k*FIFO_WIDTH +: FIFO_WIDTH] = bus.fifo_data;
            end
          end
          if (last_lane) begin
            lane_cnt_d = '0;
            state_d    = PRESENT;
          end else begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
          end
        end
      end

      PRESENT: begin
        if (bus.row_ready) begin
          row_cnt_d = row_cnt_inc[ROW_CNT_WIDTH-1:0];
          if (row_cnt_inc == {1'b0, rows_tgt_q}) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FILL;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.fifo_next_en = pop;
  assign bus.row_data     = row_data_q;
  assign bus.row_valid    = (state_q == PRESENT);

endmodule

// File: tb/tb_fifo_row_packer.sv
module tb_fifo_row_packer;

  localparam int unsigned FW = 8;
  localparam int unsigned RL = 4;
  localparam int unsigned RW = 8;

  logic clk;
  logic rst;

  fifo_row_packer_if #(.FIFO_WIDTH(FW), .ROW_LENGTH(RL), .ROW_CNT_WIDTH(RW)) bus ();

  fifo_row_packer #(.FIFO_WIDTH(FW), .ROW_LENGTH(RL), .ROW_CNT_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- show-ahead FIFO model, depth 32 ----------------
  logic [7:0] mem [32];
  logic [4:0] rd_ptr, wr_ptr;
  logic [5:0] cnt;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       do_push, do_pop;

  assign do_push        = wr_en && (cnt != 6'd32);
  assign do_pop         = bus.fifo_next_en && (cnt != 6'd0);
  assign bus.fifo_data  = mem[rd_ptr];
  assign bus.fifo_empty = (cnt == 6'd0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 5'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 5'd1;
      if (do_push && !do_pop) cnt <= cnt + 6'd1;
      else if (!do_push && do_pop) cnt <= cnt - 6'd1;
    end
  end

  // ---------------- checking infrastructure ----------------
  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_next_en) begin
        pop_cnt++;
        check("pop_while_empty", 64'(bus.fifo_empty), 64'd0);
      end
      if (bus.done) done_cnt++;
      if (bus.row_valid && bus.row_ready) begin
        check("row_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) check("row_data", 64'(bus.row_data), 64'(sb.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_cmd(input logic [7:0] n);
    bus.start    = 1'b1;
    bus.num_rows = n;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done_cnt != d0) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
    repeat (3) tick();
    check({tag, "_single"}, 64'(done_cnt - d0), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    int d0;
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_data      = '0;
    bus.start    = 1'b0;
    bus.num_rows = '0;
    bus.row_ready = 1'b0;
    repeat (3) tick();

    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_valid", 64'(bus.row_valid), 64'd0);
    check("rst_pop",   64'(bus.fifo_next_en), 64'd0);
    check("rst_data",  64'(bus.row_data), 64'd0);
    rst = 1'b0;
    tick();

    // 1: two rows back to back
    push_bytes(8'h00, 8);
    sb.push_back(32'h03020100);
    sb.push_back(32'h07060504);
    bus.row_ready = 1'b1;
    p0 = pop_cnt;
    start_cmd(8'd2);
    wait_done("t1_done", 40);
    check("t1_pops",  64'(pop_cnt - p0), 64'd8);
    check("t1_empty", 64'(bus.fifo_empty), 64'd1);
    check("t1_sb",    64'(sb.size()), 64'd0);

    // 2: start on an empty FIFO, trickle data in
    p0 = pop_cnt;
    sb.push_back(32'hA3A2A1A0);
    start_cmd(8'd1);
    repeat (5) tick();
    check("t2_stall_pop",  64'(bus.fifo_next_en), 64'd0);
    check("t2_stall_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      push_bytes(8'hA0 + 8'(i), 1);
      repeat (2) tick();
    end
    wait_done("t2_done", 20);
    check("t2_pops", 64'(pop_cnt - p0), 64'd4);
    check("t2_sb",   64'(sb.size()), 64'd0);

    // 3: back-pressure hold, also fill latency
    push_bytes(8'h10, 4);
    bus.row_ready = 1'b0;
    sb.push_back(32'h13121110);
    start_cmd(8'd1);
    repeat (3) tick();
    check("t3_valid_early", 64'(bus.row_valid), 64'd0);
    tick();
    check("t3_valid_lat", 64'(bus.row_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", 64'(bus.row_valid), 64'd1);
      check("t3_hold_data",  64'(bus.row_data), 64'h13121110);
      check("t3_hold_nopop", 64'(bus.fifo_next_en), 64'd0);
      tick();
    end
    bus.row_ready = 1'b1;
    tick();
    check("t3_done_next", 64'(bus.done), 64'd1);
    check("t3_idle",      64'(bus.busy), 64'd0);
    tick();
    check("t3_sb", 64'(sb.size()), 64'd0);

    // 4: zero-row command
    p0 = pop_cnt;
    d0 = done_cnt;
    start_cmd(8'd0);
    check("t4_done", 64'(bus.done), 64'd1);
    check("t4_busy", 64'(bus.busy), 64'd0);
    tick();
    check("t4_done_off", 64'(bus.done), 64'd0);
    check("t4_busy2",    64'(bus.busy), 64'd0);
    check("t4_pops",     64'(pop_cnt - p0), 64'd0);
    check("t4_dcnt",     64'(done_cnt - d0), 64'd1);

    // 5: reset mid-row
    push_bytes(8'h30, 4);
    start_cmd(8'd1);
    repeat (2) tick();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t5_busy",  64'(bus.busy), 64'd0);
    check("t5_valid", 64'(bus.row_valid), 64'd0);
    check("t5_pop",   64'(bus.fifo_next_en), 64'd0);
    check("t5_data",  64'(bus.row_data), 64'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check("t5_nodone", 64'(done_cnt - d0), 64'd0);
    push_bytes(8'h20, 4);
    sb.push_back(32'h23222120);
    start_cmd(8'd1);
    wait_done("t5_done", 20);
    check("t5_sb", 64'(sb.size()), 64'd0);

    // 6: start while busy must be ignored
    push_bytes(8'h40, 16);
    sb.push_back(32'h43424140);
    sb.push_back(32'h47464544);
    sb.push_back(32'h4B4A4948);
    p0 = pop_cnt;
    start_cmd(8'd3);
    repeat (2) tick();
    start_cmd(8'd9);
    wait_done("t6_done", 60);
    repeat (20) tick();
    check("t6_pops", 64'(pop_cnt - p0), 64'd12);
    check("t6_idle", 64'(bus.busy), 64'd0);
    check("t6_sb",   64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
